// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush/bubble sequencing for the 5-stage MIPS pipeline
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MDU_LAT    = 4,
  parameter int BR_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [4:0]  ifid_rs_in,
  input  logic [4:0]  ifid_rt_in,
  input  logic        ifid_uses_rt_in,
  input  logic        idex_memread_in,
  input  logic [4:0]  idex_rt_in,
  input  logic        branch_taken_in,
  input  logic        mdu_start_in,
  input  logic        dmem_busy_in,
  output logic        pc_write_out,
  output logic        ifid_write_out,
  output logic        ifid_flush_out,
  output logic        idex_write_out,
  output logic        idex_bubble_out,
  output logic        exmem_bubble_out,
  output logic        busy_out,
  output logic [15:0] stall_cnt_out
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] MDU_CNT = 4'(MDU_LAT - 2);
  localparam logic [3:0] BR_CNT  = 4'((BR_PENALTY > 1) ? (BR_PENALTY - 2) : 0);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] stall_cnt;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble;
  logic load_use;

  assign load_use = idex_memread_in && (idex_rt_in != 5'd0) &&
                    ((idex_rt_in == ifid_rs_in) ||
                     (ifid_uses_rt_in && (idex_rt_in == ifid_rt_in)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    state_nx     = state;
    cnt_nx       = cnt;
    case (state)
      RUN: begin
        if (dmem_busy_in) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
        end else if (branch_taken_in) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (BR_PENALTY > 1) begin
            state_nx = FLUSH;
            cnt_nx   = BR_CNT;
          end
        end else if (mdu_start_in) begin
          state_nx = MDU_BUSY;
          cnt_nx   = MDU_CNT;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        // A memory wait freezes the flush window, remaining count included.
        if (dmem_busy_in) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt == 4'd0) state_nx = RUN;
          else             cnt_nx   = cnt - 4'd1;
        end
      end
      MDU_BUSY: begin
        // The MDU keeps counting through a memory wait; only the bubble is suppressed.
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = ~dmem_busy_in;
        if (cnt == 4'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state     <= RUN;
      cnt       <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_write && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign pc_write_out     = ~reset_in & pc_write;
  assign ifid_write_out   = ~reset_in & ifid_write;
  assign ifid_flush_out   = ~reset_in & ifid_flush;
  assign idex_write_out   = ~reset_in & idex_write;
  assign idex_bubble_out  = ~reset_in & idex_bubble;
  assign exmem_bubble_out = ~reset_in & exmem_bubble;
  assign busy_out         = ~reset_in & (state != RUN);
  assign stall_cnt_out    = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle model of the hazard rules plus directed scenarios.
`default_nettype none

module tb_hazard_ctrl;
  localparam int MDU_LAT    = 4;
  localparam int BR_PENALTY = 3;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [4:0]  ifid_rs_in, ifid_rt_in, idex_rt_in;
  logic        ifid_uses_rt_in, idex_memread_in, branch_taken_in, mdu_start_in, dmem_busy_in;
  logic        pc_write_out, ifid_write_out, ifid_flush_out, idex_write_out;
  logic        idex_bubble_out, exmem_bubble_out, busy_out;
  logic [15:0] stall_cnt_out;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .BR_PENALTY(BR_PENALTY)) dut (
    .clk(clk), .reset_in(reset_in),
    .ifid_rs_in(ifid_rs_in), .ifid_rt_in(ifid_rt_in), .ifid_uses_rt_in(ifid_uses_rt_in),
    .idex_memread_in(idex_memread_in), .idex_rt_in(idex_rt_in),
    .branch_taken_in(branch_taken_in), .mdu_start_in(mdu_start_in), .dmem_busy_in(dmem_busy_in),
    .pc_write_out(pc_write_out), .ifid_write_out(ifid_write_out), .ifid_flush_out(ifid_flush_out),
    .idex_write_out(idex_write_out), .idex_bubble_out(idex_bubble_out),
    .exmem_bubble_out(exmem_bubble_out), .busy_out(busy_out), .stall_cnt_out(stall_cnt_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model: mode 0=run 1=flush 2=mdu; m_left = cycles still to spend in that mode.
  int m_mode = 0;
  int m_left = 0;
  int m_stall = 0;
  logic [6:0] m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, busy}
  function automatic logic [6:0] model_out();
    logic pw, iw, fl, ew, eb, mb, lu;
    pw = 1; iw = 1; fl = 0; ew = 1; eb = 0; mb = 0;
    lu = idex_memread_in && idex_rt_in != 0 &&
         (idex_rt_in == ifid_rs_in || (ifid_uses_rt_in && idex_rt_in == ifid_rt_in));
    if (m_mode == 0) begin
      if (dmem_busy_in)         begin pw = 0; iw = 0; ew = 0; end
      else if (branch_taken_in) begin fl = 1; eb = 1; end
      else if (mdu_start_in)    begin end
      else if (lu)              begin pw = 0; iw = 0; eb = 1; end
    end else if (m_mode == 1) begin
      if (dmem_busy_in) begin pw = 0; iw = 0; ew = 0; end
      else              begin fl = 1; eb = 1; end
    end else begin
      pw = 0; iw = 0; ew = 0; mb = !dmem_busy_in;
    end
    return {pw, iw, fl, ew, eb, mb, m_mode != 0};
  endfunction

  always @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      m_mode <= 0; m_left <= 0; m_stall <= 0;
    end else begin
      m_e = model_out();
      if (!m_e[6] && m_stall < 65535) m_stall <= m_stall + 1;
      if (m_mode == 0) begin
        if (!dmem_busy_in && branch_taken_in) begin
          if (BR_PENALTY > 1) begin m_mode <= 1; m_left <= BR_PENALTY - 1; end
        end else if (!dmem_busy_in && mdu_start_in) begin
          m_mode <= 2; m_left <= MDU_LAT - 1;
        end
      end else if (m_mode == 1) begin
        if (!dmem_busy_in) begin
          if (m_left == 1) m_mode <= 0;
          m_left <= m_left - 1;
        end
      end else begin
        if (m_left == 1) m_mode <= 0;
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (reset_in)
        check("reset_outs", {pc_write_out, ifid_write_out, ifid_flush_out, idex_write_out,
                             idex_bubble_out, exmem_bubble_out, busy_out, stall_cnt_out}, 32'd0);
      else begin
        check("ctrl_vec", {pc_write_out, ifid_write_out, ifid_flush_out, idex_write_out,
                           idex_bubble_out, exmem_bubble_out, busy_out}, model_out());
        check("stall_cnt", stall_cnt_out, m_stall);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs_in = 0; ifid_rt_in = 0; idex_rt_in = 0; ifid_uses_rt_in = 0;
    idex_memread_in = 0; branch_taken_in = 0; mdu_start_in = 0; dmem_busy_in = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_in = 1;
    step(1);
    reset_in = 0;
  endtask

  initial begin
    int fc;
    clear_inputs();
    reset_in = 1;
    step(2);
    reset_in = 0;
    chk_en = 1;

    // Idle after reset
    step(3);
    check("idle_enables", {pc_write_out, ifid_write_out, idex_write_out}, 3'b111);
    check("idle_busy", busy_out, 0);
    check("idle_stall", stall_cnt_out, 0);
    #2 reset_in = 1;
    #1 check("async_rst_enables", {pc_write_out, ifid_write_out, idex_write_out}, 3'b000);
    step(1);
    reset_in = 0;

    // Load-use stall
    idex_memread_in = 1; idex_rt_in = 5; ifid_rs_in = 5;
    #1 check("lu_stall", {pc_write_out, ifid_write_out, idex_bubble_out}, 3'b001);
    step(1);
    idex_memread_in = 0;
    #1 check("lu_after_pc", pc_write_out, 1);
    check("lu_stall_cnt", stall_cnt_out, 1);
    idex_memread_in = 1; idex_rt_in = 0; ifid_rs_in = 0;
    #1 check("lu_rt0", pc_write_out, 1);
    step(1);
    idex_rt_in = 7; ifid_rt_in = 7; ifid_rs_in = 3; ifid_uses_rt_in = 0;
    #1 check("lu_rt_unused", pc_write_out, 1);
    step(1);
    ifid_uses_rt_in = 1;
    #1 check("lu_rt_used", pc_write_out, 0);
    step(1);
    clear_inputs();
    step(1);

    // Branch with simultaneous load-use: flush window of BR_PENALTY cycles
    do_reset();
    branch_taken_in = 1; idex_memread_in = 1; idex_rt_in = 9; ifid_rs_in = 9;
    #1 check("br_first", {pc_write_out, ifid_flush_out, idex_bubble_out}, 3'b111);
    fc = 1;
    step(1);
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      #1 fc += ifid_flush_out;
      step(1);
    end
    check("br_flush_cycles", fc, 3);
    check("br_busy_end", busy_out, 0);
    check("br_stall", stall_cnt_out, 0);

    // MDU occupancy
    do_reset();
    mdu_start_in = 1;
    #1 check("mdu_start_normal", pc_write_out, 1);
    step(1);
    mdu_start_in = 0;
    fc = 0;
    for (int i = 0; i < 6; i++) begin
      #1 fc += exmem_bubble_out;
      step(1);
    end
    check("mdu_cycles", fc, 3);
    check("mdu_stall", stall_cnt_out, 3);

    // MDU window not extended by memory wait
    do_reset();
    mdu_start_in = 1;
    step(1);
    mdu_start_in = 0; dmem_busy_in = 1;
    #1 check("mdu_dmem_busy", busy_out, 1);
    step(3);
    check("mdu_dmem_done", busy_out, 0);
    dmem_busy_in = 0;
    step(1);

    // Memory wait in the middle of a flush window
    do_reset();
    branch_taken_in = 1;
    fc = 1;
    step(1);
    branch_taken_in = 0;
    for (int i = 0; i < 8; i++) begin
      dmem_busy_in = (i == 1 || i == 2);
      #1 fc += ifid_flush_out;
      if (i == 1) check("fl_freeze", {pc_write_out, ifid_write_out, idex_write_out, ifid_flush_out}, 4'b0000);
      step(1);
    end
    check("fl_dmem_cycles", fc, 3);

    // Saturation of the stall counter
    do_reset();
    dmem_busy_in = 1;
    step(70000);
    check("stall_sat", stall_cnt_out, 16'hFFFF);
    step(2);
    check("stall_sat_hold", stall_cnt_out, 16'hFFFF);

    // Async reset while the MDU is busy
    dmem_busy_in = 0; mdu_start_in = 1;
    step(1);
    mdu_start_in = 0;
    #1 check("mdu_busy_pre_rst", busy_out, 1);
    #2 reset_in = 1;
    #1 check("mdu_async_rst_busy", busy_out, 0);
    step(1);
    reset_in = 0;
    #1 check("post_rst_busy", busy_out, 0);
    check("post_rst_pc", pc_write_out, 1);
    step(2);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
